note_recorder: RTL and testbench

Captures the player's note entries after a challenge has been played back and checks them against the loaded level. It shares the level nibble format with the playback path: `level_data` carries up to four 4-bit notes, first note in [15:12]. It sits between the debounced note buttons and the game controller. It reports each accepted note, the running record, and a final pass/fail verdict.

---
 rtl/note_recorder.sv | 195 +++++++++++++++++++
 tb/tb_note_recorder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/note_recorder.sv
// Player note capture: records button presses after playback and scores them against the latched level.
// Optional per-note response timeout is built when NOTE_RECORDER_TIMEOUT_EN is defined.
module note_recorder #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] level_data,
  input  logic [3:0]  level_length,
  input  logic        load_level,
  input  logic        start_record,
  input  logic [3:0]  note_inputs,
  output logic [15:0] recorded_notes,
  output logic [2:0]  note_count,
  output logic        note_valid,
  output logic        done_record,
  output logic        pass,
  output logic        fail,
  output logic        timeout
);

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned NOTE_W  = 4;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned MAX_LEN = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_RELEASE,
    S_LISTEN,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   exp_data_q, exp_data_d;
  logic [CNT_W-1:0]    eff_len_q, eff_len_d;
  logic [DATA_W-1:0]   rec_q, rec_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                note_valid_q, note_valid_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic                timeout_q, timeout_d;

  logic [NOTE_W-1:0]   exp_note_c;
  logic                capture_c;
  logic [CNT_W-1:0]    count_inc_c;

`ifdef NOTE_RECORDER_TIMEOUT_EN
  localparam int unsigned TIMER_W = 32;
  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
  logic [TIMER_W-1:0]  timer_q, timer_d;
`endif

  // Expected note for the next entry, selected by how many have been accepted.
  always_comb begin
    exp_note_c = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if (count_q[1:0] == 2'(i)) begin
        exp_note_c = exp_data_q[DATA_W-1-NOTE_W*i -: NOTE_W];
      end
    end
  end

  assign capture_c   = (state_q == S_LISTEN) && (note_inputs != '0);
  assign count_inc_c = count_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    exp_data_d   = exp_data_q;
    eff_len_d    = eff_len_q;
    rec_d        = rec_q;
    count_d      = count_q;
    note_valid_d = 1'b0;
    done_d       = done_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    timeout_d    = timeout_q;
`ifdef NOTE_RECORDER_TIMEOUT_EN
    timer_d      = timer_q;
`endif

    if (load_level) begin
      exp_data_d = level_data;
      eff_len_d  = (level_length > 4'(MAX_LEN)) ? CNT_W'(MAX_LEN) : level_length[CNT_W-1:0];
      rec_d      = '0;
      count_d    = '0;
      done_d     = 1'b0;
      pass_d     = 1'b0;
      fail_d     = 1'b0;
      timeout_d  = 1'b0;
      state_d    = S_IDLE;
    end else if (start_record && (state_q == S_IDLE || state_q == S_DONE)) begin
      rec_d     = '0;
      count_d   = '0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      fail_d    = 1'b0;
      timeout_d = 1'b0;
`ifdef NOTE_RECORDER_TIMEOUT_EN
      timer_d   = TIMER_RELOAD;
`endif
      // An empty level is trivially passed.
      if (eff_len_q == '0) begin
        done_d  = 1'b1;
        pass_d  = 1'b1;
        state_d = S_DONE;
      end else begin
        state_d = S_WAIT_RELEASE;
      end
    end else if (state_q == S_WAIT_RELEASE || state_q == S_LISTEN) begin
      if (capture_c) begin
        for (int i = 0; i < int'(MAX_LEN); i++) begin
          if (count_q[1:0] == 2'(i)) begin
            rec_d[DATA_W-1-NOTE_W*i -: NOTE_W] = note_inputs;
          end
        end
        count_d      = count_inc_c;
        note_valid_d = 1'b1;
`ifdef NOTE_RECORDER_TIMEOUT_EN
        timer_d      = TIMER_RELOAD;
`endif
        if (note_inputs != exp_note_c) begin
          fail_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (count_inc_c == eff_len_q) begin
          pass_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT_RELEASE;
        end
      end
`ifdef NOTE_RECORDER_TIMEOUT_EN
      else if (timer_q == '0) begin
        fail_d    = 1'b1;
        timeout_d = 1'b1;
        done_d    = 1'b1;
        state_d   = S_DONE;
      end
`endif
      else begin
`ifdef NOTE_RECORDER_TIMEOUT_EN
        timer_d = timer_q - TIMER_W'(1);
`endif
        // Keys must be released before the next entry is listened for.
        if (state_q == S_WAIT_RELEASE && note_inputs == '0) begin
          state_d = S_LISTEN;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      exp_data_q   <= '0;
      eff_len_q    <= '0;
      rec_q        <= '0;
      count_q      <= '0;
      note_valid_q <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef NOTE_RECORDER_TIMEOUT_EN
      timer_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      exp_data_q   <= exp_data_d;
      eff_len_q    <= eff_len_d;
      rec_q        <= rec_d;
      count_q      <= count_d;
      note_valid_q <= note_valid_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      timeout_q    <= timeout_d;
`ifdef NOTE_RECORDER_TIMEOUT_EN
      timer_q      <= timer_d;
`endif
    end
  end

  assign recorded_notes = rec_q;
  assign note_count     = count_q;
  assign note_valid     = note_valid_q;
  assign done_record    = done_q;
  assign pass           = pass_q;
  assign fail           = fail_q;
  assign timeout        = timeout_q;

endmodule

// File: tb/tb_note_recorder.sv
// Bench for note_recorder: cycle vector table through a scoreboard queue, plus hand-written latency/timeout sequences.
module tb_note_recorder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] level_data;
  logic [3:0]  level_length;
  logic        load_level;
  logic        start_record;
  logic [3:0]  note_inputs;
  logic [15:0] recorded_notes;
  logic [2:0]  note_count;
  logic        note_valid, done_record, pass, fail, timeout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  note_recorder dut (
    .clk(clk), .reset(reset), .level_data(level_data), .level_length(level_length),
    .load_level(load_level), .start_record(start_record), .note_inputs(note_inputs),
    .recorded_notes(recorded_notes), .note_count(note_count), .note_valid(note_valid),
    .done_record(done_record), .pass(pass), .fail(fail), .timeout(timeout)
  );

`ifdef NOTE_RECORDER_TIMEOUT_EN
  logic [15:0] t_recorded_notes;
  logic [2:0]  t_note_count;
  logic        t_note_valid, t_done_record, t_pass, t_fail, t_timeout;

  note_recorder #(.TIMEOUT_CYCLES(8)) tdut (
    .clk(clk), .reset(reset), .level_data(level_data), .level_length(level_length),
    .load_level(load_level), .start_record(start_record), .note_inputs(note_inputs),
    .recorded_notes(t_recorded_notes), .note_count(t_note_count), .note_valid(t_note_valid),
    .done_record(t_done_record), .pass(t_pass), .fail(t_fail), .timeout(t_timeout)
  );
`endif

  typedef struct {
    logic        rst_n, ld, st;
    logic [3:0]  notes;
    logic [15:0] ldata;
    logic [3:0]  llen;
    logic [15:0] rec;
    logic [2:0]  cnt;
    logic        nv, dn, ps, fl;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] rec;
    logic [2:0]  cnt;
    logic        nv, dn, ps, fl;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic void add(logic rst_n, logic ld, logic st, logic [3:0] notes,
                              logic [15:0] ldata, logic [3:0] llen, logic [15:0] rec,
                              logic [2:0] cnt, logic nv, logic dn, logic ps, logic fl);
    vec_t v;
    v.rst_n = rst_n; v.ld = ld; v.st = st; v.notes = notes; v.ldata = ldata; v.llen = llen;
    v.rec = rec; v.cnt = cnt; v.nv = nv; v.dn = dn; v.ps = ps; v.fl = fl;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic ld, input logic st, input logic [3:0] notes,
                       input logic [15:0] ldata, input logic [3:0] llen);
    @(negedge clk);
    reset = rst_n; load_level = ld; start_record = st; note_inputs = notes;
    level_data = ldata; level_length = llen;
  endtask

  initial begin
    exp_t e;
    int   lat;
    reset = 1'b0; load_level = 1'b0; start_record = 1'b0; note_inputs = 4'h0;
    level_data = 16'h0; level_length = 4'h0;

    // rst ld st nt  ldata    len  rec      cnt nv dn ps fl
    add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 1, 0);  // empty level passes at once
    add(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 1, 0);
    // full match 1,2,4,8
    add(1, 1, 0, 0, 16'h1248, 4, 16'h0000, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 16'h1248, 4, 16'h0000, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 16'h1248, 4, 16'h0000, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 16'h1248, 4, 16'h1000, 1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 16'h1248, 4, 16'h1000, 1, 0, 0, 0, 0);
    add(1, 0, 0, 2, 16'h1248, 4, 16'h1200, 2, 1, 0, 0, 0);
    add(1, 0, 0, 0, 16'h1248, 4, 16'h1200, 2, 0, 0, 0, 0);
    add(1, 0, 0, 4, 16'h1248, 4, 16'h1240, 3, 1, 0, 0, 0);
    add(1, 0, 0, 0, 16'h1248, 4, 16'h1240, 3, 0, 0, 0, 0);
    add(1, 0, 0, 8, 16'h1248, 4, 16'h1248, 4, 1, 1, 1, 0);
    add(1, 0, 0, 0, 16'h1248, 4, 16'h1248, 4, 0, 1, 1, 0);
    // mismatch: restart from DONE, press 1 then 4
    add(1, 0, 1, 0, 16'h1248, 4, 16'h0000, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 16'h1248, 4, 16'h0000, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 16'h1248, 4, 16'h1000, 1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 16'h1248, 4, 16'h1000, 1, 0, 0, 0, 0);
    add(1, 0, 0, 4, 16'h1248, 4, 16'h1400, 2, 1, 1, 0, 1);
    add(1, 0, 0, 0, 16'h1248, 4, 16'h1400, 2, 0, 1, 0, 1);
    // held key at start, length 9 clamped to 4
    add(1, 1, 0, 2, 16'h2222, 9, 16'h0000, 0, 0, 0, 0, 0);
    add(1, 0, 1, 2, 16'h2222, 9, 16'h0000, 0, 0, 0, 0, 0);
    add(1, 0, 0, 2, 16'h2222, 9, 16'h0000, 0, 0, 0, 0, 0);
    add(1, 0, 0, 2, 16'h2222, 9, 16'h0000, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 16'h2222, 9, 16'h0000, 0, 0, 0, 0, 0);
    add(1, 0, 0, 2, 16'h2222, 9, 16'h2000, 1, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++)
      add(1, 0, 0, 2, 16'h2222, 9, 16'h2000, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 16'h2222, 9, 16'h2000, 1, 0, 0, 0, 0);
    add(1, 0, 0, 2, 16'h2222, 9, 16'h2200, 2, 1, 0, 0, 0);
    add(1, 0, 0, 0, 16'h2222, 9, 16'h2200, 2, 0, 0, 0, 0);
    add(1, 0, 0, 2, 16'h2222, 9, 16'h2220, 3, 1, 0, 0, 0);
    add(1, 0, 0, 0, 16'h2222, 9, 16'h2220, 3, 0, 0, 0, 0);
    add(1, 0, 0, 2, 16'h2222, 9, 16'h2222, 4, 1, 1, 1, 0);
    add(1, 0, 0, 2, 16'h2222, 9, 16'h2222, 4, 0, 1, 1, 0);
    // load beats a capture; start ignored mid-attempt
    add(1, 1, 0, 0, 16'h1248, 4, 16'h0000, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 16'h1248, 4, 16'h0000, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 16'h1248, 4, 16'h0000, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 16'h1248, 4, 16'h0000, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 16'h1248, 4, 16'h0000, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 16'h1248, 4, 16'h0000, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 16'h1248, 4, 16'h0000, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 16'h1248, 4, 16'h1000, 1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 16'h1248, 4, 16'h1000, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 16'h1248, 4, 16'h1000, 1, 0, 0, 0, 0);
    add(1, 0, 0, 2, 16'h1248, 4, 16'h1200, 2, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].ld, vecs[i].st, vecs[i].notes, vecs[i].ldata, vecs[i].llen);
      e.idx = i; e.rec = vecs[i].rec; e.cnt = vecs[i].cnt; e.nv = vecs[i].nv;
      e.dn = vecs[i].dn; e.ps = vecs[i].ps; e.fl = vecs[i].fl;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("recorded_notes", e.idx, recorded_notes, e.rec);
      chk("note_count", e.idx, 16'(note_count), 16'(e.cnt));
      chk("note_valid", e.idx, 16'(note_valid), 16'(e.nv));
      chk("done_record", e.idx, 16'(done_record), 16'(e.dn));
      chk("pass", e.idx, 16'(pass), 16'(e.ps));
      chk("fail", e.idx, 16'(fail), 16'(e.fl));
      chk("timeout", e.idx, 16'(timeout), 16'h0);
    end

    // single-note level: capture latency is one edge after the press
    drive(1, 1, 0, 0, 16'h5000, 1);
    drive(1, 0, 1, 0, 16'h5000, 1);
    drive(1, 0, 0, 0, 16'h5000, 1);
    drive(1, 0, 0, 5, 16'h5000, 1);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!note_valid && lat < 6);
    chk("latency", 0, 16'(lat), 16'd1);
    chk("single_pass", 0, 16'(pass), 16'h1);
    chk("single_rec", 0, recorded_notes, 16'h5000);

`ifdef NOTE_RECORDER_TIMEOUT_EN
    // no press: expiry lands on the 8th edge after start
    drive(0, 0, 0, 0, 16'h1248, 4);
    drive(1, 1, 0, 0, 16'h1248, 4);
    drive(1, 0, 1, 0, 16'h1248, 4);
    for (int k = 1; k <= 8; k++) begin
      drive(1, 0, 0, 0, 16'h1248, 4);
      @(posedge clk);
      #1;
      chk("to_fail", k, 16'(t_fail), (k == 8) ? 16'h1 : 16'h0);
      chk("to_timeout", k, 16'(t_timeout), (k == 8) ? 16'h1 : 16'h0);
    end
    // press on the expiry edge is captured instead
    drive(1, 1, 0, 0, 16'h1248, 4);
    drive(1, 0, 1, 0, 16'h1248, 4);
    for (int k = 1; k <= 7; k++) drive(1, 0, 0, 0, 16'h1248, 4);
    drive(1, 0, 0, 1, 16'h1248, 4);
    @(posedge clk);
    #1;
    chk("race_valid", 0, 16'(t_note_valid), 16'h1);
    chk("race_count", 0, 16'(t_note_count), 16'h1);
    chk("race_timeout", 0, 16'(t_timeout), 16'h0);
    drive(1, 0, 0, 0, 16'h1248, 4);
    @(posedge clk);
    #1;
    chk("race_reload", 0, 16'(t_fail), 16'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
